labmininios_sys_pll_supervisor: RTL

Parametrised lock supervisor and staged reset sequencer for the system PLLs, including the SDRAM controller/SDRAM clock pair. It drives the PLL reset and retries with a timeout if the PLL does not lock. Lock must be stable before any downstream reset is released, then up to NUM_CH reset domains are released in order with programmable spacing. A lost lock re-asserts every downstream reset and increments a saturating event counter.

---
 rtl/labmininios_sys_pll_supervisor_if.sv | 40 ++++
 rtl/labmininios_sys_pll_supervisor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/labmininios_sys_pll_supervisor_if.sv
// Control and status bundle of the PLL lock supervisor.
// The supervisor drives the slave side; the controller drives master.
interface labmininios_sys_pll_supervisor_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);
  logic              pll_locked;
  logic              soft_reset;
  logic              status_clr;
  logic              pll_rst;
  logic [NUM_CH-1:0] rst_out_n;
  logic              ready;
  logic              lock_lost;
  logic [CNT_W-1:0]  loss_count;
  logic [2:0]        state;

  modport slave (
    input  pll_locked,
    input  soft_reset,
    input  status_clr,
    output pll_rst,
    output rst_out_n,
    output ready,
    output lock_lost,
    output loss_count,
    output state
  );

  modport master (
    output pll_locked,
    output soft_reset,
    output status_clr,
    input  pll_rst,
    input  rst_out_n,
    input  ready,
    input  lock_lost,
    input  loss_count,
    input  state
  );
endinterface

// File: rtl/labmininios_sys_pll_supervisor.sv
// PLL lock supervisor with retry timeout and staged reset release.
// Runs entirely on refclk; pll_locked is synchronised before use.
module labmininios_sys_pll_supervisor #(
  parameter int NUM_CH             = 2,
  parameter int PLL_RST_CYCLES     = 8,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY        = 16,
  parameter int CNT_W              = 8
) (
  input  logic refclk,
  input  logic rst_n,
  labmininios_sys_pll_supervisor_if.slave bus
);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  localparam int T_RST = PLL_RST_CYCLES - 1;
  localparam int T_TO  = LOCK_TIMEOUT - 1;
  localparam int T_STB = LOCK_STABLE_CYCLES - 1;
  localparam int T_REL = NUM_CH * STAGE_DELAY - 1;
  localparam int M_A   = (T_RST > T_TO) ? T_RST : T_TO;
  localparam int M_B   = (T_STB > T_REL) ? T_STB : T_REL;
  localparam int MAXT  = (M_A > M_B) ? M_A : M_B;
  localparam int CW    = (MAXT < 1) ? 1 : $clog2(MAXT + 1);

  localparam logic [CW-1:0] C_RST = CW'(T_RST);
  localparam logic [CW-1:0] C_TO  = CW'(T_TO);
  localparam logic [CW-1:0] C_STB = CW'(T_STB);
  localparam logic [CW-1:0] C_REL = CW'(T_REL);
  localparam logic [CW-1:0] ONE   = CW'(1);

  localparam logic [CNT_W-1:0] LC_MAX = '1;
  localparam logic [CNT_W-1:0] LC_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] rel_q, rel_d;
  logic              pll_rst_q, pll_rst_d;
  logic              ready_q, ready_d;
  logic              lost_q, lost_d;
  logic [CNT_W-1:0]  lcnt_q, lcnt_d;
  logic [1:0]        sync_q;
  logic              locked_s;
  logic              loss;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  assign loss = !locked_s &&
                (state_q == S_RELEASE || state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    unique case (state_q)
      S_PLL_RESET: begin
        if (cnt_q == C_RST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == C_TO) begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_STABILIZE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == C_STB) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_RELEASE: begin
        if (loss) begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
          rel_d   = '0;
        end else begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (cnt_q == CW'(k * STAGE_DELAY)) rel_d[k] = 1'b1;
          end
          if (cnt_q == C_REL) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_RUN: begin
        if (loss) begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
          rel_d   = '0;
        end else begin
          rel_d = '1;
        end
      end
      default: begin
        state_d = S_PLL_RESET;
        cnt_d   = '0;
        rel_d   = '0;
      end
    endcase
    // soft_reset beats loss/timeout moves but not the loss bookkeeping
    if (bus.soft_reset) begin
      state_d = S_PLL_RESET;
      cnt_d   = '0;
      rel_d   = '0;
    end
    pll_rst_d = (state_d == S_PLL_RESET);
    ready_d   = (state_d == S_RUN);
  end

  always_comb begin
    lost_d = lost_q;
    lcnt_d = lcnt_q;
    if (loss) begin
      lost_d = 1'b1;
      if (bus.status_clr) begin
        lcnt_d = LC_ONE;
      end else if (lcnt_q != LC_MAX) begin
        lcnt_d = lcnt_q + LC_ONE;
      end
    end else if (bus.status_clr) begin
      lost_d = 1'b0;
      lcnt_d = '0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PLL_RESET;
      cnt_q     <= '0;
      rel_q     <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      lost_q    <= 1'b0;
      lcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      lost_q    <= lost_d;
      lcnt_q    <= lcnt_d;
    end
  end

  assign bus.pll_rst    = pll_rst_q;
  assign bus.rst_out_n  = rel_q;
  assign bus.ready      = ready_q;
  assign bus.lock_lost  = lost_q;
  assign bus.loss_count = lcnt_q;
  assign bus.state      = state_q;

endmodule
